// File: rtl/regfile_dump_reader.sv
// Debug readout engine: walks the register file through a spare read port and
// streams (address, data) beats over valid/ready while summing accepted data.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_rd_add,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_add,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // abort overrides everything, including a handshake and the done pulse
  always_comb begin
    state_next = state;
    rf_rd_add  = '0;
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_next = FETCH;
      end
      FETCH: begin
        rf_rd_add  = idx;
        busy       = 1'b1;
        state_next = abort ? IDLE : SEND;
      end
      SEND: begin
        dump_valid = 1'b1;
        busy       = 1'b1;
        if (abort)           state_next = IDLE;
        else if (dump_ready) state_next = dump_last ? DONE : FETCH;
      end
      DONE: begin
        done       = !abort;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // beat registers hold their last values in IDLE; checksum persists until next start
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      idx       <= '0;
      dump_add  <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            checksum <= '0;
            idx      <= '0;
          end
        end
        FETCH: begin
          if (!abort) begin
            dump_data <= rf_rd_data;
            dump_add  <= idx;
            dump_last <= (idx == LAST_IDX);
          end
        end
        SEND: begin
          if (!abort && dump_ready) begin
            checksum <= checksum + dump_data;
            if (!dump_last) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_regfile_dump_reader;

  localparam int NUM_REGS = 32;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  rf_rd_add;
  logic [31:0] rf_rd_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_add;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] regs [NUM_REGS];
  logic        wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [4:0]  wr_addr0 = '0, wr_addr1 = '0;
  logic [31:0] wr_data0 = '0, wr_data1 = '0;

  int checks = 0;
  int errors = 0;

  regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .clear(clear), .start(start), .abort(abort),
    .rf_rd_add(rf_rd_add), .rf_rd_data(rf_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_add(dump_add), .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // register file: combinational read, write lands at the clock edge
  assign rf_rd_data = regs[rf_rd_add];
  always @(posedge clk) begin
    if (wr_en0) regs[wr_addr0] <= wr_data0;
    if (wr_en1) regs[wr_addr1] <= wr_data1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // reference model: phase 0 idle, 1 fetching, 2 offering a beat, 3 finished
  int          m_phase = 0;
  logic [4:0]  m_idx = '0;
  logic [4:0]  m_add = '0;
  logic [31:0] m_data = '0;
  logic        m_last = 1'b0;
  logic [31:0] m_sum = '0;

  always @(negedge clk) begin
    if (clear) begin
      checkOutput("rst_valid", 32'(dump_valid), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_checksum", checksum, 0);
      checkOutput("rst_add", 32'(dump_add), 0);
      m_phase = 0; m_idx = '0; m_add = '0; m_data = '0; m_last = 1'b0; m_sum = '0;
    end else begin
      checkOutput("rf_rd_add", 32'(rf_rd_add), (m_phase == 1) ? 32'(m_idx) : 0);
      checkOutput("dump_valid", 32'(dump_valid), 32'(m_phase == 2));
      checkOutput("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      checkOutput("done", 32'(done), 32'(m_phase == 3 && !abort));
      checkOutput("dump_add", 32'(dump_add), 32'(m_add));
      checkOutput("dump_data", dump_data, m_data);
      checkOutput("dump_last", 32'(dump_last), 32'(m_last));
      checkOutput("checksum", checksum, m_sum);
      case (m_phase)
        0: if (start && !abort) begin m_sum = '0; m_idx = '0; m_phase = 1; end
        1: if (abort) m_phase = 0;
           else begin
             m_data = regs[m_idx]; m_add = m_idx; m_last = (int'(m_idx) == NUM_REGS - 1);
             m_phase = 2;
           end
        2: if (abort) m_phase = 0;
           else if (dump_ready) begin
             m_sum = m_sum + m_data;
             if (m_last) m_phase = 3;
             else begin m_idx = m_idx + 5'd1; m_phase = 1; end
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit s, input bit a, input bit r);
    start = s; abort = a; dump_ready = r;
  endtask

  task automatic waitBeat(input int addr);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (dump_valid && int'(dump_add) == addr) begin ok = 1; break; end
      tick();
    end
    checkOutput("beat_timeout", 32'(ok), 1);
  endtask

  task automatic waitDone();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin ok = 1; break; end
      tick();
    end
    checkOutput("done_timeout", 32'(ok), 1);
  endtask

  task automatic startDump();
    applyStimulus(1, 0, 1);
    tick();
    applyStimulus(0, 0, 1);
  endtask

  initial begin
    int busy_cycles;
    bit saw_done;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h100 + i;
    tick(); tick();
    clear = 1'b0;
    tick();
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_checksum", checksum, 0);

    // full dump without backpressure
    startDump();
    busy_cycles = 0;
    saw_done = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin saw_done = 1; break; end
      if (busy) busy_cycles++;
      tick();
    end
    checkOutput("full_done_seen", 32'(saw_done), 1);
    checkOutput("full_busy_cycles", busy_cycles, 64);
    checkOutput("full_checksum", checksum, 32'h0000_21F0);
    tick();
    checkOutput("full_done_once", 32'(done), 0);

    // backpressure on beat 3
    startDump();
    waitBeat(3);
    dump_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_add", 32'(dump_add), 3);
      checkOutput("bp_data", dump_data, 32'h103);
      checkOutput("bp_checksum", checksum, 32'h303);
    end
    dump_ready = 1'b1;
    waitDone();
    checkOutput("bp_checksum_final", checksum, 32'h0000_21F0);
    tick();

    // abort with a same-cycle handshake on beat 10
    startDump();
    waitBeat(10);
    applyStimulus(0, 1, 1);
    tick();
    applyStimulus(0, 0, 1);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_valid", 32'(dump_valid), 0);
    checkOutput("abort_checksum", checksum, 32'h0000_0A2D);
    tick();
    checkOutput("abort_no_done", 32'(done), 0);

    // writes during beat 5: reg 20 is ahead of the walk, reg 2 is behind it
    startDump();
    waitBeat(5);
    wr_en0 = 1; wr_addr0 = 5'd20; wr_data0 = 32'hDEAD_BEEF;
    wr_en1 = 1; wr_addr1 = 5'd2;  wr_data1 = 32'h55AA_55AA;
    tick();
    wr_en0 = 0; wr_en1 = 0;
    waitBeat(20);
    checkOutput("cw_beat20", dump_data, 32'hDEAD_BEEF);
    waitDone();
    checkOutput("cw_checksum", checksum, 32'hDEAD_DFCB);
    wr_en0 = 1; wr_addr0 = 5'd20; wr_data0 = 32'h114;
    wr_en1 = 1; wr_addr1 = 5'd2;  wr_data1 = 32'h102;
    tick();
    wr_en0 = 0; wr_en1 = 0;

    // start while busy is ignored, then clear mid-dump and restart cleanly
    startDump();
    waitBeat(4);
    applyStimulus(1, 0, 1);
    tick();
    applyStimulus(0, 0, 1);
    waitBeat(15);
    clear = 1'b1;
    #1;
    checkOutput("clr_busy", 32'(busy), 0);
    checkOutput("clr_valid", 32'(dump_valid), 0);
    checkOutput("clr_checksum", checksum, 0);
    checkOutput("clr_data", dump_data, 0);
    checkOutput("clr_add", 32'(dump_add), 0);
    tick();
    clear = 1'b0;
    tick();
    checkOutput("clr_no_done", 32'(done), 0);
    startDump();
    waitBeat(0);
    checkOutput("restart_data0", dump_data, 32'h100);
    waitDone();
    checkOutput("restart_checksum", checksum, 32'h0000_21F0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0);
      wr_en0   = ($urandom_range(0, 3) == 0);
      wr_addr0 = 5'($urandom_range(0, NUM_REGS - 1));
      wr_data0 = $urandom;
      tick();
    end
    applyStimulus(0, 0, 0);
    wr_en0 = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
